score_board_n: RTL and testbench
================================

Name: score_board_n

Overview:
- Parametrised score display engine for the drum game.
- Counts judged hits from the hit-judge stage into a DIGITS-wide BCD score and a binary combo count.
- Continuously scans every pixel of every score digit, producing glyph-ROM addresses and VGA-adapter plot strobes.
- All logic runs on CLOCK_50: edge-detected hit input, saturating arithmetic, tear-free snapshot per scan frame, ROM-latency-aligned pixel output.

Parameters:
- DIGITS, 3, number of decimal score digits (1..6)
- DIGIT_W, 15, glyph width in pixels
- DIGIT_H, 15, glyph height in pixels
- GAP, 5, horizontal pixels between adjacent glyphs
- X0, 8'd99, screen x of left edge of most significant digit
- Y0, 7'd0, screen y of top edge of all digits
- ADDR_W, 9, glyph ROM address width (must satisfy 2^ADDR_W >= DIGIT_W*DIGIT_H)
- ROM_LAT, 1, glyph ROM read latency in cycles (1..2)

Ports:
- CLOCK_50  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- hit_valid  in  1  judge result present (level; may stay high several cycles)
- hit_grade  in  2  00 miss, 01 good, 10 great, 11 big
- clear  in  1  synchronous score/combo clear
- glyph_digit  out  4  BCD value whose glyph is being fetched
- glyph_addr  out  ADDR_W  pixel index within glyph, row-major
- glyph_color  in  3  ROM data, valid ROM_LAT cycles after glyph_digit/glyph_addr
- x  out  8  plot x
- y  out  7  plot y
- colour  out  3  plot colour (registered glyph_color)
- plot  out  1  pixel write strobe
- score_bcd  out  4*DIGITS  live score, digit 0 in bits [3:0]
- combo  out  8  consecutive non-miss count
- saturated  out  1  score pinned at all nines

Behaviour:
- Reset (async, resetn=0) sets the following:
  - score_bcd=0, combo=0, saturated=0
  - snapshot=0, hit_prev=1
  - scan digit index=DIGITS-1, px=0, py=0
  - glyph_addr=0, glyph_digit=0
  - x=0, y=0, colour=0, plot=0
  - all pipeline valid bits=0
- Reset may assert mid-scan or mid-update. It aborts immediately, and operation restarts from the reset state on the first edge after release.
- Hit event = hit_valid & ~hit_prev, with hit_prev registered each cycle. A level held high at reset release produces no event.
- On an event at edge N, hit_grade is sampled at edge N; score_bcd, combo and saturated update at edge N (visible after N).
- Increment: 00 -> +0, 01 -> +1, 10 -> +2, 11 -> +3.
- BCD add of 0..3 into digit 0 with single-cycle ripple carry through all digits.
- If the true sum exceeds 10^DIGITS-1: score_bcd = all nines, saturated=1. saturated stays set until clear or reset.
- combo: a miss sets combo to 0; any other grade sets combo to combo+1, saturating at 255.
- clear=1: score_bcd, combo and saturated go to 0 at the next edge. Clear wins over a simultaneous hit event, and that event is discarded. Clear does not disturb the scan.
- Scan (one pixel per cycle, never stalls):
  - Order: digit index DIGITS-1 down to 0; within a digit px 0..DIGIT_W-1, then py 0..DIGIT_H-1.
  - glyph_addr = py*DIGIT_W+px.
  - glyph_digit = snapshot nibble of the current digit.
- Frame wrap: after px=DIGIT_W-1, py=DIGIT_H-1, digit 0, the scan returns to digit DIGITS-1, (0,0). On that same edge the snapshot reloads from score_bcd. The snapshot is never loaded mid-frame.
- Screen coordinates:
  - x = X0 + (DIGITS-1-d)*(DIGIT_W+GAP) + px
  - y = Y0 + py
  - Computed at fetch time and delayed ROM_LAT cycles. Arithmetic is 8/7 bit, truncating; parameter choice keeps results on screen.
- Output alignment: x, y, colour and plot are registered together. plot=1 on every cycle whose pipelined valid bit is set.
- First plot occurs ROM_LAT+1 edges after reset release; after that plot stays 1 continuously.
- Frame length: DIGITS*DIGIT_W*DIGIT_H cycles (675 at defaults).

Test Plan:
- Reset, then hit_valid pulses with grades 01,10,11,00 -> score_bcd 001,003,006,006; combo 1,2,3,0.
- hit_valid held high 10 cycles with grade 10 -> exactly one +2; score_bcd=002.
- Preload 998 via hits, then grade 11 -> score_bcd=999, saturated=1; further hits keep 999; clear -> 000, saturated=0.
- clear and a grade-10 edge in the same cycle -> score_bcd=000, combo=0.
- Score 047 at frame start, hit +2 mid-frame -> glyph_digit sequence 0,4,7 for the rest of that frame. Next frame shows 0,4,9. First plot at x=99, y=0; first pixel of digit 0 at x=139.
- ROM_LAT=2 and ROM model stub returning glyph_addr[2:0] -> colour equals address of the same pixel's x/y. 675 consecutive plot cycles per frame. Assert resetn mid-frame -> plot=0 immediately.

Source files
------------

// File: rtl/score_board_n_if.sv
// Score engine bus bundle.
// Groups the hit-judge inputs, the glyph-ROM fetch/return path, the VGA
// plot outputs and the live score outputs of score_board_n.
//   master : environment side (drives hit_valid/hit_grade/clear/glyph_color)
//   slave  : score engine side (drives glyph/plot/score outputs)
interface score_board_n_if #(
    parameter int DIGITS = 3,
    parameter int ADDR_W = 9
);
    logic                  hit_valid;
    logic [1:0]            hit_grade;
    logic                  clear;
    logic [3:0]            glyph_digit;
    logic [ADDR_W-1:0]     glyph_addr;
    logic [2:0]            glyph_color;
    logic [7:0]            x;
    logic [6:0]            y;
    logic [2:0]            colour;
    logic                  plot;
    logic [4*DIGITS-1:0]   score_bcd;
    logic [7:0]            combo;
    logic                  saturated;

    modport master (
        output hit_valid, hit_grade, clear, glyph_color,
        input  glyph_digit, glyph_addr, x, y, colour, plot,
               score_bcd, combo, saturated
    );

    modport slave (
        input  hit_valid, hit_grade, clear, glyph_color,
        output glyph_digit, glyph_addr, x, y, colour, plot,
               score_bcd, combo, saturated
    );
endinterface

// File: rtl/score_board_n.sv
// Drum-game score display engine.
// Accumulates judged hits into a saturating BCD score and a binary combo
// count, and scans every pixel of every score digit continuously, issuing
// glyph-ROM reads and ROM-latency-aligned VGA plot strobes.
// Ports:
//   CLOCK_50 : system clock
//   resetn   : asynchronous active-low reset
//   bus      : score_board_n_if.slave (hit input, clear, glyph ROM, plot, score)
module score_board_n #(
    parameter int          DIGITS  = 3,
    parameter int          DIGIT_W = 15,
    parameter int          DIGIT_H = 15,
    parameter int          GAP     = 5,
    parameter logic [7:0]  X0      = 8'd99,
    parameter logic [6:0]  Y0      = 7'd0,
    parameter int          ADDR_W  = 9,
    parameter int          ROM_LAT = 1
) (
    input  logic           CLOCK_50,
    input  logic           resetn,
    score_board_n_if.slave bus
);
    localparam int                  DW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [7:0]          PITCH    = 8'(DIGIT_W + GAP);
    localparam logic [7:0]          PX_LAST  = 8'(DIGIT_W - 1);
    localparam logic [6:0]          PY_LAST  = 7'(DIGIT_H - 1);
    localparam logic [DW-1:0]       DIG_LAST = DW'(DIGITS - 1);
    localparam logic [4*DIGITS-1:0] NINES    = {DIGITS{4'h9}};

    // Ripple BCD add of 0..3 into digit 0; MSB of the result is the carry
    // out of the top digit, i.e. the true sum no longer fits.
    function automatic logic [4*DIGITS:0] bcd_add(input logic [4*DIGITS-1:0] val,
                                                  input logic [1:0]          inc);
        logic [4*DIGITS-1:0] sum;
        logic [4:0]          addend;
        logic [4:0]          dsum;
        sum    = {(4*DIGITS){1'b0}};
        addend = {3'b000, inc};
        for (int i = 0; i < DIGITS; i++) begin
            dsum = {1'b0, val[4*i +: 4]} + addend;
            if (dsum > 5'd9) begin
                sum[4*i +: 4] = 4'(dsum - 5'd10);
                addend        = 5'd1;
            end else begin
                sum[4*i +: 4] = dsum[3:0];
                addend        = 5'd0;
            end
        end
        return {addend[0], sum};
    endfunction

    logic [4*DIGITS-1:0] score_q, score_d, snap_q, snap_d;
    logic [7:0]          combo_q, combo_d;
    logic                sat_q, sat_d;
    logic                hit_prev_q, hit_prev_d;
    logic [DW-1:0]       dig_q, dig_d;
    logic [7:0]          px_q, px_d;
    logic [6:0]          py_q, py_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          digit_q, digit_d;
    logic [7:0]          pipe_x_q [ROM_LAT];
    logic [7:0]          pipe_x_d [ROM_LAT];
    logic [6:0]          pipe_y_q [ROM_LAT];
    logic [6:0]          pipe_y_d [ROM_LAT];
    logic                pipe_v_q [ROM_LAT];
    logic                pipe_v_d [ROM_LAT];
    logic [7:0]          x_q, x_d;
    logic [6:0]          y_q, y_d;
    logic [2:0]          colour_q, colour_d;
    logic                plot_q, plot_d;
    logic                hit_event_s;
    logic [4*DIGITS:0]   add_s;
    logic                wrap_s;
    logic [7:0]          slot_s;

    // Score/combo update: clear dominates, then a rising-edge hit event.
    always_comb begin
        hit_event_s = bus.hit_valid & ~hit_prev_q;
        hit_prev_d  = bus.hit_valid;
        add_s       = bcd_add(score_q, bus.hit_grade);
        score_d     = score_q;
        combo_d     = combo_q;
        sat_d       = sat_q;
        if (bus.clear) begin
            score_d = {(4*DIGITS){1'b0}};
            combo_d = 8'd0;
            sat_d   = 1'b0;
        end else if (hit_event_s) begin
            if (add_s[4*DIGITS]) begin
                score_d = NINES;
                sat_d   = 1'b1;
            end else begin
                score_d = add_s[4*DIGITS-1:0];
                sat_d   = sat_q;
            end
            if (bus.hit_grade == 2'b00) begin
                combo_d = 8'd0;
            end else if (combo_q == 8'hFF) begin
                combo_d = combo_q;
            end else begin
                combo_d = combo_q + 8'd1;
            end
        end else begin
            score_d = score_q;
        end
    end

    // Scan walker: px inner, py outer, digits MS to LS; the snapshot only
    // reloads on the frame wrap so a frame never mixes two scores.
    always_comb begin
        px_d   = px_q;
        py_d   = py_q;
        dig_d  = dig_q;
        addr_d = addr_q;
        wrap_s = 1'b0;
        if (px_q != PX_LAST) begin
            px_d   = px_q + 8'd1;
            addr_d = addr_q + ADDR_W'(1'b1);
        end else if (py_q != PY_LAST) begin
            px_d   = 8'd0;
            py_d   = py_q + 7'd1;
            addr_d = addr_q + ADDR_W'(1'b1);
        end else if (dig_q != {DW{1'b0}}) begin
            px_d   = 8'd0;
            py_d   = 7'd0;
            addr_d = {ADDR_W{1'b0}};
            dig_d  = dig_q - DW'(1'b1);
        end else begin
            px_d   = 8'd0;
            py_d   = 7'd0;
            addr_d = {ADDR_W{1'b0}};
            dig_d  = DIG_LAST;
            wrap_s = 1'b1;
        end
        snap_d  = wrap_s ? score_q : snap_q;
        digit_d = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            digit_d = (dig_d == DW'(i)) ? snap_d[4*i +: 4] : digit_d;
        end
    end

    // Screen position of the pixel whose address is on the ROM this cycle,
    // delayed alongside the ROM read so x/y/colour/plot leave together.
    always_comb begin
        slot_s      = 8'(DIG_LAST - dig_q);
        pipe_x_d[0] = X0 + slot_s * PITCH + px_q;
        pipe_y_d[0] = Y0 + py_q;
        pipe_v_d[0] = 1'b1;
        for (int i = 1; i < ROM_LAT; i++) begin
            pipe_x_d[i] = pipe_x_q[i-1];
            pipe_y_d[i] = pipe_y_q[i-1];
            pipe_v_d[i] = pipe_v_q[i-1];
        end
        x_d      = pipe_x_q[ROM_LAT-1];
        y_d      = pipe_y_q[ROM_LAT-1];
        plot_d   = pipe_v_q[ROM_LAT-1];
        colour_d = bus.glyph_color;
    end

    // State registers; reset places the scan on the first pixel of the MS digit.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            score_q    <= {(4*DIGITS){1'b0}};
            combo_q    <= 8'd0;
            sat_q      <= 1'b0;
            snap_q     <= {(4*DIGITS){1'b0}};
            hit_prev_q <= 1'b1;
            dig_q      <= DIG_LAST;
            px_q       <= 8'd0;
            py_q       <= 7'd0;
            addr_q     <= {ADDR_W{1'b0}};
            digit_q    <= 4'd0;
            for (int i = 0; i < ROM_LAT; i++) begin
                pipe_x_q[i] <= 8'd0;
                pipe_y_q[i] <= 7'd0;
                pipe_v_q[i] <= 1'b0;
            end
            x_q        <= 8'd0;
            y_q        <= 7'd0;
            colour_q   <= 3'd0;
            plot_q     <= 1'b0;
        end else begin
            score_q    <= score_d;
            combo_q    <= combo_d;
            sat_q      <= sat_d;
            snap_q     <= snap_d;
            hit_prev_q <= hit_prev_d;
            dig_q      <= dig_d;
            px_q       <= px_d;
            py_q       <= py_d;
            addr_q     <= addr_d;
            digit_q    <= digit_d;
            for (int i = 0; i < ROM_LAT; i++) begin
                pipe_x_q[i] <= pipe_x_d[i];
                pipe_y_q[i] <= pipe_y_d[i];
                pipe_v_q[i] <= pipe_v_d[i];
            end
            x_q        <= x_d;
            y_q        <= y_d;
            colour_q   <= colour_d;
            plot_q     <= plot_d;
        end
    end

    assign bus.score_bcd   = score_q;
    assign bus.combo       = combo_q;
    assign bus.saturated   = sat_q;
    assign bus.glyph_addr  = addr_q;
    assign bus.glyph_digit = digit_q;
    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.colour      = colour_q;
    assign bus.plot        = plot_q;
endmodule

// File: tb/tb_score_board_n.sv
module tb_score_board_n;
    localparam int DIGITS  = 3;
    localparam int ADDR_W  = 9;
    localparam int ROM_LAT = 2;
    localparam int GLYPH   = 225;
    localparam int FRAME   = 675;

    logic clk = 1'b0;
    logic resetn;
    always #10 clk = ~clk;

    score_board_n_if #(.DIGITS(DIGITS), .ADDR_W(ADDR_W)) bus ();

    score_board_n #(
        .DIGITS(DIGITS), .DIGIT_W(15), .DIGIT_H(15), .GAP(5),
        .X0(8'd99), .Y0(7'd0), .ADDR_W(ADDR_W), .ROM_LAT(ROM_LAT)
    ) dut (
        .CLOCK_50(clk),
        .resetn(resetn),
        .bus(bus.slave)
    );

    // Glyph ROM stub: returns glyph_addr[2:0] two cycles later.
    logic [2:0] rom_s1, rom_s2;
    always @(posedge clk) begin
        rom_s1 <= bus.glyph_addr[2:0];
        rom_s2 <= rom_s1;
    end
    assign bus.glyph_color = rom_s2;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Expected {x, y, colour} of the p-th scanned pixel since reset.
    function automatic logic [17:0] pix(input int p);
        int q, slot, w;
        q    = p % FRAME;
        slot = q / GLYPH;
        w    = q % GLYPH;
        return {8'(99 + slot * 20 + (w % 15)), 7'(w / 15), 3'(w % 8)};
    endfunction

    // Reference model state
    int         m_score = 0;
    int         m_combo = 0;
    int         m_sat   = 0;
    int         m_prev  = 1;
    int         m_snap  = 0;
    int         e_cnt   = 0;
    int         m_ev;
    int         exp_sc[$];
    logic [17:0] exp_px[$];

    // Model: integer score with clamping, per-frame snapshot, pixel order.
    initial begin
        forever begin
            @(posedge clk);
            if (!resetn) begin
                m_score = 0; m_combo = 0; m_sat = 0; m_prev = 1; m_snap = 0; e_cnt = 0;
                exp_sc.delete();
                exp_px.delete();
            end else begin
                e_cnt++;
                if (e_cnt % FRAME == 0) m_snap = m_score;
                m_ev   = (bus.hit_valid && m_prev == 0) ? 1 : 0;
                m_prev = bus.hit_valid ? 1 : 0;
                if (bus.clear) begin
                    m_score = 0; m_combo = 0; m_sat = 0;
                end else if (m_ev == 1) begin
                    if (m_score + int'(bus.hit_grade) > 999) begin
                        m_score = 999; m_sat = 1;
                    end else begin
                        m_score = m_score + int'(bus.hit_grade);
                    end
                    if (bus.hit_grade == 2'd0) m_combo = 0;
                    else if (m_combo < 255) m_combo++;
                end
                exp_sc.push_back(m_score * 512 + m_combo * 2 + m_sat);
                exp_px.push_back(pix(e_cnt - 1));
            end
        end
    end

    // Monitor: pops expected entries whenever the DUT presents them.
    initial begin
        int v, q, slot, pw;
        logic [17:0] p;
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (exp_sc.size() == 0) begin
                    chk("score_queue_empty", 32'd1, 32'd0);
                end else begin
                    v = exp_sc.pop_front();
                    chk("score_bcd", 32'(bus.score_bcd), 32'(to_bcd(v / 512)));
                    chk("combo", 32'(bus.combo), 32'((v / 2) % 256));
                    chk("saturated", 32'(bus.saturated), 32'(v % 2));
                end
                chk("plot", 32'(bus.plot), (e_cnt >= ROM_LAT + 1) ? 32'd1 : 32'd0);
                if (bus.plot) begin
                    if (exp_px.size() == 0) begin
                        chk("pixel_queue_empty", 32'd1, 32'd0);
                    end else begin
                        p = exp_px.pop_front();
                        chk("x", 32'(bus.x), 32'(p[17:10]));
                        chk("y", 32'(bus.y), 32'(p[9:3]));
                        chk("colour", 32'(bus.colour), 32'(p[2:0]));
                    end
                end
                q    = e_cnt % FRAME;
                slot = q / GLYPH;
                pw   = (slot == 0) ? 100 : ((slot == 1) ? 10 : 1);
                chk("glyph_addr", 32'(bus.glyph_addr), 32'(q % GLYPH));
                chk("glyph_digit", 32'(bus.glyph_digit), 32'((m_snap / pw) % 10));
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic hit(input logic [1:0] g);
        bus.hit_valid = 1'b1;
        bus.hit_grade = g;
        step();
        bus.hit_valid = 1'b0;
        step();
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        step();
    endtask

    task automatic chk_score(input string name, input logic [11:0] s, input int c, input int sat);
        chk({name, "_score"}, 32'(bus.score_bcd), 32'(s));
        chk({name, "_combo"}, 32'(bus.combo), 32'(c));
        chk({name, "_sat"}, 32'(bus.saturated), 32'(sat));
    endtask

    initial begin
        bus.hit_valid = 1'b0;
        bus.hit_grade = 2'd0;
        bus.clear     = 1'b0;
        resetn        = 1'b1;
        #1 resetn = 1'b0;
        repeat (3) step();
        chk_score("reset", 12'h000, 0, 0);
        chk("reset_plot", 32'(bus.plot), 32'd0);
        chk("reset_x", 32'(bus.x), 32'd0);
        chk("reset_y", 32'(bus.y), 32'd0);
        chk("reset_colour", 32'(bus.colour), 32'd0);
        chk("reset_addr", 32'(bus.glyph_addr), 32'd0);
        chk("reset_digit", 32'(bus.glyph_digit), 32'd0);
        resetn = 1'b1;
        step();

        hit(2'b01); chk_score("g01", 12'h001, 1, 0);
        hit(2'b10); chk_score("g10", 12'h003, 2, 0);
        hit(2'b11); chk_score("g11", 12'h006, 3, 0);
        hit(2'b00); chk_score("g00", 12'h006, 0, 0);

        // Level held for 10 cycles counts once.
        do_clear();
        bus.hit_valid = 1'b1;
        bus.hit_grade = 2'b10;
        repeat (10) step();
        bus.hit_valid = 1'b0;
        step();
        chk_score("held", 12'h002, 1, 0);

        // Saturation at 999.
        do_clear();
        repeat (332) hit(2'b11);
        hit(2'b10);
        chk_score("pre998", 12'h998, 255, 0);
        hit(2'b11);
        chk_score("sat999", 12'h999, 255, 1);
        hit(2'b01);
        chk_score("sat_hold", 12'h999, 255, 1);
        hit(2'b00);
        chk_score("sat_miss", 12'h999, 0, 1);
        do_clear();
        chk_score("sat_clear", 12'h000, 0, 0);

        // Clear beats a simultaneous hit edge.
        hit(2'b01);
        bus.hit_valid = 1'b1;
        bus.hit_grade = 2'b10;
        bus.clear     = 1'b1;
        step();
        bus.hit_valid = 1'b0;
        bus.clear     = 1'b0;
        step();
        chk_score("clr_vs_hit", 12'h000, 0, 0);

        // Reach 047, let a frame start, then +2 mid-frame.
        repeat (15) hit(2'b11);
        hit(2'b10);
        chk_score("s047", 12'h047, 16, 0);
        for (int i = 0; i < FRAME && (e_cnt % FRAME) != 5; i++) step();
        repeat (295) step();
        hit(2'b10);
        chk_score("s049", 12'h049, 17, 0);
        repeat (2 * FRAME) step();

        // Random traffic.
        repeat (400) begin
            bus.hit_valid = 1'($urandom_range(0, 1));
            bus.hit_grade = 2'($urandom_range(0, 3));
            bus.clear     = ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0;
            step();
        end
        bus.clear     = 1'b0;
        bus.hit_valid = 1'b1;
        bus.hit_grade = 2'b11;
        step();

        // Mid-frame reset with hit_valid held high through release.
        @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        chk("midrst_plot", 32'(bus.plot), 32'd0);
        chk("midrst_x", 32'(bus.x), 32'd0);
        chk_score("midrst", 12'h000, 0, 0);
        repeat (2) step();
        resetn = 1'b1;
        repeat (3) step();
        chk_score("held_release", 12'h000, 0, 0);
        bus.hit_valid = 1'b0;
        repeat (FRAME + 10) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
